// File: rtl/kernel_stream_src_uv_pkg.sv
// Shared definitions for the u/v stream source feeding the coriolis kernel.
// Holds the run-controller state encoding, default widths and a helper that
// sizes the FIFO occupancy counters.
package kernel_stream_src_uv_pkg;

   // Default width of one stream word (u or v)
   localparam int STREAMW_DEF = 34;
   // Default entries per channel FIFO (power of 2, >= 2)
   localparam int DEPTH_DEF   = 8;
   // Default width of the element counter / nelem
   localparam int NELEM_W_DEF = 32;

   // Run controller states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Occupancy counter width: one extra bit so "full" (== depth) is representable
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/kernel_stream_src_uv_if.sv
// Bundle of all handshake/bus signals of the u/v stream source.
//
// Handshake rule (applies to both loader channels and the kernel stream):
//   a word moves on a rising clk edge exactly when its valid and ready are
//   both high; valid never depends combinationally on ready, and once the
//   stream valid is high it stays high with stable data until it transfers.
//
// Signals:
//   start/nelem            run launch pulse and element count
//   wr_valid_x/wr_data_x   loader push for channel x (u, v)
//   wr_ready_x             channel x FIFO has room
//   u_s0/v_s0              stream words to kernel (0 while not valid)
//   ivalid_u_s0/v_s0       stream valids (always equal)
//   iready                 kernel ready shared by both channels
//   busy/done              run in progress / end-of-run pulse
// Modports: master = the stream source, slave = its environment.
interface kernel_stream_src_uv_if
   import kernel_stream_src_uv_pkg::*;
#(
   parameter int STREAMW = STREAMW_DEF,
   parameter int NELEM_W = NELEM_W_DEF
);
   logic               start;
   logic [NELEM_W-1:0] nelem;
   logic               wr_valid_u;
   logic [STREAMW-1:0] wr_data_u;
   logic               wr_ready_u;
   logic               wr_valid_v;
   logic [STREAMW-1:0] wr_data_v;
   logic               wr_ready_v;
   logic [STREAMW-1:0] u_s0;
   logic [STREAMW-1:0] v_s0;
   logic               ivalid_u_s0;
   logic               ivalid_v_s0;
   logic               iready;
   logic               busy;
   logic               done;

   modport master (
      input  start, nelem, wr_valid_u, wr_data_u, wr_valid_v, wr_data_v, iready,
      output wr_ready_u, wr_ready_v, u_s0, v_s0, ivalid_u_s0, ivalid_v_s0, busy, done
   );

   modport slave (
      output start, nelem, wr_valid_u, wr_data_u, wr_valid_v, wr_data_v, iready,
      input  wr_ready_u, wr_ready_v, u_s0, v_s0, ivalid_u_s0, ivalid_v_s0, busy, done
   );
endinterface

// File: rtl/kernel_stream_src_uv_fifo.sv
// Synchronous single-clock FIFO used once per stream channel.
// A word pushed at edge t is at the head after that edge. Push acceptance
// (ready_o) depends only on the registered count, so a full FIFO refuses a
// push even in a cycle where it is popped.
//
// Ports:
//   clk, rst   clock, synchronous active-low reset (clears pointers/count)
//   push_i     push request; accepted when ready_o
//   data_i     word to push
//   pop_i      pop request; ignored when empty
//   ready_o    count < DEPTH
//   count_o    current occupancy
//   head_o     word at the head (undefined content when empty)
module kernel_stream_src_uv_fifo
   import kernel_stream_src_uv_pkg::*;
#(
   parameter int W     = STREAMW_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push_i,
   input  logic [W-1:0]            data_i,
   input  logic                    pop_i,
   output logic                    ready_o,
   output logic [cnt_w(DEPTH)-1:0] count_o,
   output logic [W-1:0]            head_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = cnt_w(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign ready_o = (count_q < FULL_CNT);
   assign do_push = push_i & ready_o;
   assign do_pop  = pop_i & (count_q != '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Pointers wrap naturally since DEPTH is a power of 2
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the cleared count makes old contents unreachable
   always_ff @(posedge clk) begin
      if (rst && do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/kernel_stream_src_uv.sv
// Transmit-side stream source for the two-input coriolis kernel.
// The loader fills independent u and v FIFOs at any time; a start pulse in
// IDLE launches a run that emits exactly nelem lock-stepped (u,v) pairs.
// Words beyond nelem stay buffered for the next run.
//
// Ports:
//   clk       single clock
//   rst       synchronous active-low reset; abandons any run and empties FIFOs
//   bus       master view of kernel_stream_src_uv_if (loader, kernel, control)
//   state_o   current run-controller state, for observation
module kernel_stream_src_uv
   import kernel_stream_src_uv_pkg::*;
#(
   parameter int STREAMW = STREAMW_DEF,
   parameter int DEPTH   = DEPTH_DEF,
   parameter int NELEM_W = NELEM_W_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   kernel_stream_src_uv_if.master        bus,
   output state_t                        state_o
);
   localparam int CW = cnt_w(DEPTH);
   localparam logic [NELEM_W-1:0] REM_ONE = NELEM_W'(1);

   state_t             state_q;
   logic [NELEM_W-1:0] remaining_q;
   logic               busy_q, done_q;

   logic [CW-1:0]      count_u, count_v;
   logic [STREAMW-1:0] head_u, head_v;
   logic               have_pair, ivalid, fire;

   // Both channels are presented together because the kernel ANDs the valids
   assign have_pair = (count_u != '0) && (count_v != '0);
   assign ivalid    = busy_q & have_pair;
   assign fire      = ivalid & bus.iready;

   kernel_stream_src_uv_fifo #(.W(STREAMW), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (bus.wr_valid_u),
      .data_i  (bus.wr_data_u),
      .pop_i   (fire),
      .ready_o (bus.wr_ready_u),
      .count_o (count_u),
      .head_o  (head_u)
   );

   kernel_stream_src_uv_fifo #(.W(STREAMW), .DEPTH(DEPTH)) v_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (bus.wr_valid_v),
      .data_i  (bus.wr_data_v),
      .pop_i   (fire),
      .ready_o (bus.wr_ready_v),
      .count_o (count_v),
      .head_o  (head_v)
   );

   assign bus.ivalid_u_s0 = ivalid;
   assign bus.ivalid_v_s0 = ivalid;
   assign bus.u_s0        = ivalid ? head_u : '0;
   assign bus.v_s0        = ivalid ? head_v : '0;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign state_o         = state_q;

   // busy_q/done_q are registered copies of (state==RUN)/(state==DONE)
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  if (bus.nelem != '0) begin
                     remaining_q <= bus.nelem;
                     state_q     <= ST_RUN;
                     busy_q      <= 1'b1;
                  end else begin
                     // Empty run still reports completion
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (fire) begin
                  remaining_q <= remaining_q - REM_ONE;
                  if (remaining_q == REM_ONE) begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_kernel_stream_src_uv.sv
module tb_kernel_stream_src_uv;
   import kernel_stream_src_uv_pkg::*;

   localparam int W     = 34;
   localparam int DEPTH = 8;
   localparam int NW    = 32;

   // ---------------- clock / reset ----------------
   logic   clk = 1'b0;
   logic   rst = 1'b0;
   state_t dbg_state;
   always #5 clk = ~clk;

   kernel_stream_src_uv_if #(.STREAMW(W), .NELEM_W(NW)) bus ();

   kernel_stream_src_uv #(.STREAMW(W), .DEPTH(DEPTH), .NELEM_W(NW)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .state_o (dbg_state)
   );

   // ---------------- scoreboard / reference model ----------------
   // Model contents of each channel FIFO as queues; run progress as a phase.
   localparam int PH_WAIT = 0, PH_EMIT = 1, PH_FINISH = 2;
   logic [W-1:0] exp_u_q[$];
   logic [W-1:0] exp_v_q[$];
   int  m_phase = PH_WAIT;
   int  m_left  = 0;
   bit  model_ok = 1'b0;
   int  n_cmp = 0;
   int  n_err = 0;
   int  n_xfer_seen = 0;
   bit  seen_done = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      bit exp_valid;
      exp_valid = (m_phase == PH_EMIT) && (exp_u_q.size() != 0) && (exp_v_q.size() != 0);
      check("wr_ready_u",  64'(bus.wr_ready_u),  64'(exp_u_q.size() < DEPTH));
      check("wr_ready_v",  64'(bus.wr_ready_v),  64'(exp_v_q.size() < DEPTH));
      check("ivalid_u",    64'(bus.ivalid_u_s0), 64'(exp_valid));
      check("ivalid_v",    64'(bus.ivalid_v_s0), 64'(exp_valid));
      check("u_s0",        64'(bus.u_s0),        exp_valid ? 64'(exp_u_q[0]) : 64'(0));
      check("v_s0",        64'(bus.v_s0),        exp_valid ? 64'(exp_v_q[0]) : 64'(0));
      check("busy",        64'(bus.busy),        64'(m_phase == PH_EMIT));
      check("done",        64'(bus.done),        64'(m_phase == PH_FINISH));
   endtask

   // One clock: check at the falling edge, advance the model by the rules
   // applied to the inputs currently driven, then step to the next falling edge.
   task automatic cycle();
      bit xfer, acc_u, acc_v;
      if (model_ok) begin
         check_outputs();
         if (bus.ivalid_u_s0 && bus.iready) n_xfer_seen++;
         if (bus.done) seen_done = 1'b1;
      end
      if (!rst) begin
         exp_u_q.delete();
         exp_v_q.delete();
         m_phase  = PH_WAIT;
         m_left   = 0;
         model_ok = 1'b1;
      end else if (model_ok) begin
         xfer  = (m_phase == PH_EMIT) && (exp_u_q.size() != 0) && (exp_v_q.size() != 0) && bus.iready;
         acc_u = bus.wr_valid_u && (exp_u_q.size() < DEPTH);
         acc_v = bus.wr_valid_v && (exp_v_q.size() < DEPTH);
         if (xfer) begin
            exp_u_q.delete(0);
            exp_v_q.delete(0);
            m_left--;
         end
         if (acc_u) exp_u_q.push_back(bus.wr_data_u);
         if (acc_v) exp_v_q.push_back(bus.wr_data_v);
         case (m_phase)
            PH_WAIT: if (bus.start) begin
               if (bus.nelem != 0) begin
                  m_phase = PH_EMIT;
                  m_left  = int'(bus.nelem);
               end else begin
                  m_phase = PH_FINISH;
               end
            end
            PH_EMIT: if (xfer && m_left == 0) m_phase = PH_FINISH;
            default: m_phase = PH_WAIT;
         endcase
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      bus.start      = 1'b0;
      bus.nelem      = '0;
      bus.wr_valid_u = 1'b0;
      bus.wr_data_u  = '0;
      bus.wr_valid_v = 1'b0;
      bus.wr_data_v  = '0;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b0;
      for (int i = 0; i < n; i++) cycle();
      rst = 1'b1;
   endtask

   task automatic load_pair(input logic [W-1:0] u, input logic [W-1:0] v);
      bus.wr_valid_u = 1'b1;
      bus.wr_data_u  = u;
      bus.wr_valid_v = 1'b1;
      bus.wr_data_v  = v;
      cycle();
      bus.wr_valid_u = 1'b0;
      bus.wr_valid_v = 1'b0;
   endtask

   task automatic pulse_start(input int n);
      bus.start = 1'b1;
      bus.nelem = NW'(n);
      cycle();
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      seen_done = 1'b0;
      for (int i = 0; i < budget && !seen_done; i++) cycle();
      check(tag, 64'(seen_done), 64'(1));
   endtask

   function automatic logic [W-1:0] rnd_word();
      logic [W-1:0] w;
      w = {2'($urandom_range(3, 0)), 32'($urandom)};
      return w;
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      idle_inputs();
      bus.iready = 1'b0;
      @(negedge clk);
      do_reset(2);

      // In-order burst with kernel always ready
      bus.iready = 1'b1;
      for (int i = 1; i <= 4; i++) load_pair(W'(i), W'(10 + i));
      n_xfer_seen = 0;
      pulse_start(4);
      wait_done("t1_done", 20);
      check("t1_xfers", 64'(n_xfer_seen), 64'(4));
      cycle();
      check("t1_busy_after", 64'(bus.busy), 64'(0));

      // Kernel backpressure: alternating ready
      do_reset(1);
      for (int i = 0; i < 4; i++) load_pair(rnd_word(), rnd_word());
      n_xfer_seen = 0;
      pulse_start(4);
      seen_done = 1'b0;
      for (int i = 0; i < 30 && !seen_done; i++) begin
         bus.iready = ~i[0];
         cycle();
      end
      check("t2_done", 64'(seen_done), 64'(1));
      check("t2_xfers", 64'(n_xfer_seen), 64'(4));

      // Channel skew: v words arrive three cycles after u
      do_reset(1);
      bus.iready = 1'b1;
      n_xfer_seen = 0;
      pulse_start(2);
      for (int i = 0; i < 6; i++) begin
         bus.wr_valid_u = (i < 2);
         bus.wr_data_u  = rnd_word();
         bus.wr_valid_v = (i >= 3 && i < 5);
         bus.wr_data_v  = rnd_word();
         cycle();
      end
      idle_inputs();
      wait_done("t3_done", 10);
      check("t3_xfers", 64'(n_xfer_seen), 64'(2));

      // Full u FIFO refuses the ninth word; one pop frees space
      do_reset(1);
      for (int i = 0; i < 9; i++) begin
         bus.wr_valid_u = 1'b1;
         bus.wr_data_u  = W'(100 + i);
         cycle();
         if (i == 7) check("t4_full_ready", 64'(bus.wr_ready_u), 64'(0));
      end
      bus.wr_valid_u = 1'b0;
      load_pair(W'(0), W'(200));
      bus.wr_valid_u = 1'b0;
      pulse_start(1);
      wait_done("t4_done", 10);
      check("t4_ready_after_pop", 64'(bus.wr_ready_u), 64'(1));

      // Empty run; start during RUN is ignored
      do_reset(1);
      n_xfer_seen = 0;
      pulse_start(0);
      wait_done("t5_empty_done", 4);
      check("t5_empty_xfers", 64'(n_xfer_seen), 64'(0));
      for (int i = 0; i < 4; i++) load_pair(rnd_word(), rnd_word());
      bus.iready = 1'b0;
      n_xfer_seen = 0;
      pulse_start(3);
      pulse_start(1);
      bus.iready = 1'b1;
      wait_done("t5_done", 12);
      check("t5_xfers", 64'(n_xfer_seen), 64'(3));

      // Reset mid-run discards buffered data
      do_reset(1);
      for (int i = 0; i < 5; i++) load_pair(rnd_word(), rnd_word());
      n_xfer_seen = 0;
      pulse_start(5);
      for (int i = 0; i < 10 && n_xfer_seen < 2; i++) cycle();
      check("t6_two_xfers", 64'(n_xfer_seen), 64'(2));
      do_reset(1);
      check("t6_ivalid", 64'(bus.ivalid_u_s0), 64'(0));
      check("t6_busy", 64'(bus.busy), 64'(0));
      check("t6_wr_ready", 64'(bus.wr_ready_u), 64'(1));
      for (int i = 0; i < 2; i++) load_pair(rnd_word(), rnd_word());
      n_xfer_seen = 0;
      pulse_start(2);
      wait_done("t6_done", 10);
      check("t6_xfers", 64'(n_xfer_seen), 64'(2));

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         bus.wr_valid_u = ($urandom_range(2, 0) != 0);
         bus.wr_data_u  = rnd_word();
         bus.wr_valid_v = ($urandom_range(2, 0) != 0);
         bus.wr_data_v  = rnd_word();
         bus.iready     = ($urandom_range(3, 0) != 0);
         bus.start      = ($urandom_range(7, 0) == 0);
         bus.nelem      = NW'($urandom_range(6, 0));
         cycle();
      end
      idle_inputs();
      for (int i = 0; i < 5; i++) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
